itrx_apbm_arb: RTL and testbench

ITRX_APBM_ARB -- requirements
Module: itrx_apbm_arb

---
 rtl/itrx_apbm_arb_if.sv | 24 ++
 rtl/itrx_apbm_arb.sv | 174 +++++++++++++++++
 tb/tb_itrx_apbm_arb.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/itrx_apbm_arb_if.sv
// APB bus bundle between the two-requester arbiter (master) and one APB slave.
interface itrx_apbm_arb_if #(
  parameter int ADDR_BITS_N = 3,
  parameter int DATA_BITS_M = 8
);
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [ADDR_BITS_N-1:0] paddr;
  logic [DATA_BITS_M-1:0] pwdata;
  logic [DATA_BITS_M-1:0] prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/itrx_apbm_arb.sv
// Round-robin arbiter letting the SPI bridge (0) and the sequencer (1) share one
// APB master port, with a per-transfer pready timeout.
module itrx_apbm_arb #(
  parameter int ADDR_BITS_N = 3,
  parameter int DATA_BITS_M = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic [1:0]               req_start,
  input  logic [1:0]               req_write,
  input  logic [2*ADDR_BITS_N-1:0] req_addr,
  input  logic [2*DATA_BITS_M-1:0] req_wdata,
  output logic [1:0]               req_done,
  output logic [DATA_BITS_M-1:0]   req_rdata,
  output logic                     req_err,
  itrx_apbm_arb_if.master          apb,
  output logic [1:0]               dbg_state
);

  // Requester handshake: req_start is a one-cycle pulse accepted only while that
  // requester has no pending request; req_done is a one-cycle pulse with the result.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t                 state_q, state_d;
  logic [1:0]             valid_q, valid_d;
  logic [1:0]             pend_write_q, pend_write_d;
  logic [ADDR_BITS_N-1:0] pend_addr_q [2];
  logic [ADDR_BITS_N-1:0] pend_addr_d [2];
  logic [DATA_BITS_M-1:0] pend_wdata_q [2];
  logic [DATA_BITS_M-1:0] pend_wdata_d [2];
  logic                   grant_q, grant_d;
  logic                   last_q, last_d;
  logic [7:0]             wait_q, wait_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_BITS_N-1:0] paddr_q, paddr_d;
  logic [DATA_BITS_M-1:0] pwdata_q, pwdata_d;
  logic [1:0]             done_q, done_d;
  logic [DATA_BITS_M-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;

  always_comb begin
    logic gnt;
    gnt          = 1'b0;
    state_d      = state_q;
    valid_d      = valid_q;
    pend_write_d = pend_write_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    grant_d      = grant_q;
    last_d       = last_q;
    wait_d       = wait_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    done_d       = 2'b00;
    rdata_d      = rdata_q;
    err_d        = err_q;

    for (int i = 0; i < 2; i++) begin
      if (req_start[i] && !valid_q[i]) begin
        valid_d[i]      = 1'b1;
        pend_write_d[i] = req_write[i];
        pend_addr_d[i]  = req_addr[i*ADDR_BITS_N +: ADDR_BITS_N];
        pend_wdata_d[i] = req_wdata[i*DATA_BITS_M +: DATA_BITS_M];
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        // Arbitration looks only at registered valids, so a same-cycle start waits a cycle.
        if (|valid_q) begin
          gnt      = (&valid_q) ? ~last_q : valid_q[1];
          grant_d  = gnt;
          psel_d   = 1'b1;
          pwrite_d = pend_write_q[gnt];
          paddr_d  = pend_addr_q[gnt];
          pwdata_d = pend_wdata_q[gnt];
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        wait_d    = 8'd0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        wait_d = wait_q + 8'd1;
        if (apb.pready) begin
          rdata_d          = pwrite_q ? '0 : apb.prdata;
          err_d            = apb.pslverr;
          done_d[grant_q]  = 1'b1;
          psel_d           = 1'b0;
          penable_d        = 1'b0;
          state_d          = ST_DONE;
        end else if (wait_q == WAIT_LAST) begin
          rdata_d          = '0;
          err_d            = 1'b1;
          done_d[grant_q]  = 1'b1;
          psel_d           = 1'b0;
          penable_d        = 1'b0;
          state_d          = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_d[grant_q] = 1'b0;
        last_d           = grant_q;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= 2'b00;
      pend_write_q <= 2'b00;
      pend_addr_q  <= '{default: '0};
      pend_wdata_q <= '{default: '0};
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      wait_q       <= 8'd0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      done_q       <= 2'b00;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      pend_write_q <= pend_write_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      wait_q       <= wait_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign req_done    = done_q;
  assign req_rdata   = rdata_q;
  assign req_err     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_itrx_apbm_arb.sv
// Bench for itrx_apbm_arb: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of the arbiter's rules.
module tb_itrx_apbm_arb;
  localparam int A = 3;
  localparam int D = 8;
  localparam int T = 4;

  localparam int PH_IDLE   = 0;
  localparam int PH_SETUP  = 1;
  localparam int PH_ACCESS = 2;
  localparam int PH_DONE   = 3;

  logic           pclk;
  logic           tb_rst;
  logic [1:0]     tb_start;
  logic [1:0]     tb_write;
  logic [2*A-1:0] tb_addr;
  logic [2*D-1:0] tb_wdata;
  logic [1:0]     req_done;
  logic [D-1:0]   req_rdata;
  logic           req_err;
  logic [1:0]     dbg_state;

  itrx_apbm_arb_if #(.ADDR_BITS_N(A), .DATA_BITS_M(D)) apb_bus ();

  itrx_apbm_arb #(.ADDR_BITS_N(A), .DATA_BITS_M(D), .TIMEOUT_CYC(T)) dut (
    .pclk      (pclk),
    .rst       (tb_rst),
    .req_start (tb_start),
    .req_write (tb_write),
    .req_addr  (tb_addr),
    .req_wdata (tb_wdata),
    .req_done  (req_done),
    .req_rdata (req_rdata),
    .req_err   (req_err),
    .apb       (apb_bus.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  // behavioural model state
  bit           m_valid [2];
  logic         m_w [2];
  logic [A-1:0] m_a [2];
  logic [D-1:0] m_d [2];
  int           mp;
  int           m_gnt;
  int           m_last;
  int           m_acc;
  logic [A-1:0] m_pa;
  logic [D-1:0] m_pd;
  logic         m_pw;
  logic [D-1:0] m_rd;
  logic         m_er;

  // slave policy: 0 random, 1 ready at once, 2 never ready, 3 ready after sl_wait waits
  int           sl_mode = 0;
  int           sl_wait = 0;
  int           sl_err  = 2;
  logic [D-1:0] sl_rdata = '0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) m_valid[i] = 1'b0;
    mp     = PH_IDLE;
    m_gnt  = 0;
    m_last = 1;
    m_acc  = 0;
    m_pa   = '0;
    m_pd   = '0;
    m_pw   = 1'b0;
    m_rd   = '0;
    m_er   = 1'b0;
  endfunction

  task automatic set_req(int i, bit w, int a, int d);
    tb_start[i]         = 1'b1;
    tb_write[i]         = w;
    tb_addr[i*A +: A]   = A'(a);
    tb_wdata[i*D +: D]  = D'(d);
  endtask

  // one clock cycle: compare outputs with the model, drive the slave, advance the model
  task automatic step();
    logic [3:0]   exp_ctl;
    logic         rdy;
    logic         serr;
    logic [D-1:0] rd;
    bit           nv [2];
    int           np;
    int           g;

    exp_ctl = {(mp == PH_SETUP) || (mp == PH_ACCESS), (mp == PH_ACCESS), 2'b00};
    if (mp == PH_DONE) exp_ctl[m_gnt] = 1'b1;
    check_eq("ctl_sel_en_done", {apb_bus.psel, apb_bus.penable, req_done}, exp_ctl);
    check_eq("paddr", apb_bus.paddr, m_pa);
    check_eq("pwdata", apb_bus.pwdata, m_pd);
    check_eq("pwrite", apb_bus.pwrite, m_pw);
    check_eq("req_rdata", req_rdata, m_rd);
    check_eq("req_err", req_err, m_er);
    if (req_done != 2'b00) n_done++;

    if (mp == PH_ACCESS) begin
      case (sl_mode)
        0:       rdy = ($urandom_range(0, 2) == 0);
        1:       rdy = 1'b1;
        2:       rdy = 1'b0;
        default: rdy = (m_acc >= sl_wait);
      endcase
      rd   = (sl_mode == 3) ? sl_rdata : D'($urandom);
      serr = (sl_err == 2) ? ($urandom_range(0, 3) == 0) : (sl_err != 0);
    end else begin
      rdy  = 1'($urandom_range(0, 1));
      rd   = D'($urandom);
      serr = 1'($urandom_range(0, 1));
    end
    apb_bus.pready  = rdy;
    apb_bus.prdata  = rd;
    apb_bus.pslverr = serr;

    if (tb_rst) begin
      model_reset();
    end else begin
      nv = m_valid;
      np = mp;
      case (mp)
        PH_IDLE: begin
          if (m_valid[0] || m_valid[1]) begin
            if (m_valid[0] && m_valid[1]) g = 1 - m_last;
            else                          g = m_valid[1] ? 1 : 0;
            m_gnt = g;
            m_pa  = m_a[g];
            m_pd  = m_d[g];
            m_pw  = m_w[g];
            np    = PH_SETUP;
          end
        end
        PH_SETUP: begin
          m_acc = 0;
          np    = PH_ACCESS;
        end
        PH_ACCESS: begin
          m_acc++;
          if (rdy) begin
            m_rd = m_w[m_gnt] ? '0 : rd;
            m_er = serr;
            np   = PH_DONE;
          end else if (m_acc == T) begin
            m_rd = '0;
            m_er = 1'b1;
            np   = PH_DONE;
          end
        end
        default: begin
          m_last = m_gnt;
          np     = PH_IDLE;
        end
      endcase
      for (int i = 0; i < 2; i++) begin
        if (tb_start[i] && !m_valid[i]) begin
          nv[i]  = 1'b1;
          m_w[i] = tb_write[i];
          m_a[i] = tb_addr[i*A +: A];
          m_d[i] = tb_wdata[i*D +: D];
        end
      end
      if (mp == PH_DONE) nv[m_gnt] = 1'b0;
      m_valid = nv;
      mp      = np;
    end

    @(negedge pclk);
    tb_start = 2'b00;
    tb_rst   = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  initial begin
    tb_rst          = 1'b1;
    tb_start        = 2'b00;
    tb_write        = 2'b00;
    tb_addr         = '0;
    tb_wdata        = '0;
    apb_bus.pready  = 1'b0;
    apb_bus.prdata  = '0;
    apb_bus.pslverr = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    tb_rst = 1'b0;
    model_reset();

    // single write, ready on first ACCESS
    sl_mode = 1; sl_err = 0;
    set_req(0, 1'b1, 5, 'hA5);
    run(6);

    // read with three wait states
    sl_mode = 3; sl_wait = 3; sl_rdata = 8'h3C;
    set_req(1, 1'b0, 2, 0);
    run(9);

    // ties straight after reset, then a second tie
    tb_rst = 1'b1;
    step();
    sl_mode = 1;
    set_req(0, 1'b0, 1, 0);
    set_req(1, 1'b1, 6, 'h11);
    run(10);
    set_req(0, 1'b1, 3, 'h22);
    set_req(1, 1'b0, 4, 0);
    run(10);

    // timeout with pready held low
    sl_mode = 2;
    set_req(0, 1'b0, 7, 0);
    run(9);

    // slave error on write, duplicate starts while busy
    sl_mode = 3; sl_wait = 2; sl_err = 1;
    set_req(1, 1'b1, 6, 'h5A);
    run(2);
    for (int k = 0; k < 5; k++) begin
      set_req(1, 1'b0, 0, 'hFF);
      step();
    end
    run(3);

    // reset during ACCESS, then a tie as from reset
    sl_mode = 2; sl_err = 0;
    set_req(1, 1'b0, 1, 0);
    run(3);
    tb_rst = 1'b1;
    step();
    sl_mode = 1;
    set_req(0, 1'b1, 2, 'h77);
    set_req(1, 1'b1, 5, 'h88);
    run(10);

    // random traffic
    sl_mode = 0; sl_err = 2;
    for (int c = 0; c < 1500; c++) begin
      tb_start = 2'($urandom_range(0, 4) == 0) | (2'($urandom_range(0, 4) == 0) << 1);
      tb_write = 2'($urandom);
      tb_addr  = (2*A)'($urandom);
      tb_wdata = (2*D)'($urandom);
      tb_rst   = ($urandom_range(0, 299) == 0);
      step();
    end

    check_eq("some_transfers_completed", (n_done > 20), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
